// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: one requester's operand handshake and product return channel.
interface mul_arbiter_if;
   logic        valid;
   logic        ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] p;
   modport master (output valid, a, b, rsp_ready, input ready, rsp_valid, p);
   modport slave  (input valid, a, b, rsp_ready, output ready, rsp_valid, p);
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one free-running 32x32 multiplier between two requesters.
module mul_arbiter #(
   parameter int HOLD_CYCLES = 36
) (
   input  logic          clk,
   input  logic          rst,
   mul_arbiter_if.slave  req0,
   mul_arbiter_if.slave  req1,
   output logic [31:0]   mul_a,
   output logic [31:0]   mul_b,
   input  logic [63:0]   mul_out,
   output logic          busy
);
   localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
   state_t        state_q, state_d;
   logic          ptr_q, ptr_d, own_q, own_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   res_q, res_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic          idle, any, gnt, last, done;
   always_comb begin
      idle  = state_q == IDLE;
      any   = req0.valid | req1.valid;
      // preferred requester wins if valid, otherwise the other one
      gnt   = (ptr_q ? req1.valid : req0.valid) ? ptr_q : ~ptr_q;
      last  = cnt_q == CW'(HOLD_CYCLES - 1);
      done  = state_q == RESP && (own_q ? req1.rsp_ready : req0.rsp_ready);
      req0.ready     = !rst && idle && any && !gnt;
      req1.ready     = !rst && idle && any && gnt;
      req0.rsp_valid = state_q == RESP && !own_q;
      req1.rsp_valid = state_q == RESP && own_q;
      req0.p         = res_q;
      req1.p         = res_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      a_d     = a_q;
      b_d     = b_q;
      if (idle && any) begin
         state_d = RUN;
         own_d   = gnt;
         cnt_d   = '0;
         a_d     = gnt ? req1.a : req0.a;
         b_d     = gnt ? req1.b : req0.b;
      end else if (state_q == RUN) begin
         cnt_d   = last ? cnt_q : cnt_q + CW'(1);
         res_d   = last ? mul_out : res_q;
         state_d = last ? RESP : RUN;
      end else if (done) begin
         state_d = IDLE;
         ptr_d   = ~own_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         own_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end
   assign mul_a = a_q;
   assign mul_b = b_q;
   assign busy  = !idle;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter with a pipelined multiplier model.
module tb_mul_arbiter;
   localparam int HOLD = 36;
   logic        clk = 0;
   logic        rst = 1;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_out, m1;
   logic        busy;
   int          n_tests = 0, n_fail = 0, cyc = 0;
   logic [63:0] q0[$], q1[$];
   int          gq[$];
   int          acc_cyc[2], pop_cyc[2];
   logic        pv0 = 0, pv1 = 0;
   logic [63:0] hold_p;
   int          seen;
   mul_arbiter_if r0();
   mul_arbiter_if r1();
   mul_arbiter #(.HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst(rst), .req0(r0), .req1(r1),
      .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      m1      <= $signed(mul_a) * $signed(mul_b);
      mul_out <= m1;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction
   // scoreboard: push on accept, pop and compare on response handshake
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q0.delete();
         q1.delete();
         pv0 = 0;
         pv1 = 0;
      end else begin
         chk("one_ready", {63'd0, r0.ready & r1.ready}, 0);
         if (r0.valid && r0.ready) begin q0.push_back(prod(r0.a, r0.b)); gq.push_back(0); acc_cyc[0] = cyc; end
         if (r1.valid && r1.ready) begin q1.push_back(prod(r1.a, r1.b)); gq.push_back(1); acc_cyc[1] = cyc; end
         if (r0.rsp_valid && !pv0) chk("lat0", 64'(cyc - acc_cyc[0]), HOLD + 1);
         if (r1.rsp_valid && !pv1) chk("lat1", 64'(cyc - acc_cyc[1]), HOLD + 1);
         if (r0.rsp_valid && r1.rsp_valid) chk("both_rsp", 1, 0);
         if (r0.rsp_valid && r0.rsp_ready) begin
            if (q0.size() == 0) chk("stale0", r0.p, 64'hx);
            else chk("p0", r0.p, q0.pop_front());
            pop_cyc[0] = cyc;
         end
         if (r1.rsp_valid && r1.rsp_ready) begin
            if (q1.size() == 0) chk("stale1", r1.p, 64'hx);
            else chk("p1", r1.p, q1.pop_front());
            pop_cyc[1] = cyc;
         end
         pv0 = r0.rsp_valid;
         pv1 = r1.rsp_valid;
      end
   end
   task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b);
      int t = 0;
      @(posedge clk); #1;
      if (id) begin r1.a = a; r1.b = b; r1.valid = 1; end
      else begin r0.a = a; r0.b = b; r0.valid = 1; end
      do begin @(negedge clk); t++; end while (!(id ? r1.ready : r0.ready) && t < 500);
      chk("send_ready", {63'd0, id ? r1.ready : r0.ready}, 1);
   endtask
   task automatic drop(input bit id);
      @(posedge clk); #1;
      if (id) r1.valid = 0; else r0.valid = 0;
   endtask
   task automatic wait_rsp(input bit id, input logic [63:0] exp, input string tag);
      int t = 0;
      do begin @(negedge clk); t++; end while (!(id ? r1.rsp_valid : r0.rsp_valid) && t < 200);
      chk({tag, "_v"}, {63'd0, id ? r1.rsp_valid : r0.rsp_valid}, 1);
      chk(tag, id ? r1.p : r0.p, exp);
   endtask
   task automatic drain();
      int t = 0;
      do begin @(negedge clk); t++; end while ((q0.size() != 0 || q1.size() != 0 || busy) && t < 2000);
      chk("drain", 64'(q0.size() + q1.size()) + {63'd0, busy}, 0);
   endtask
   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
   endtask
   initial begin
      r0.valid = 0; r0.a = 0; r0.b = 0; r0.rsp_ready = 1;
      r1.valid = 0; r1.a = 0; r1.b = 0; r1.rsp_ready = 1;
      r0.valid = 1;
      repeat (3) @(negedge clk);
      chk("rst_ready0", {63'd0, r0.ready}, 0);
      chk("rst_busy", {63'd0, busy}, 0);
      chk("rst_rsp0_v", {63'd0, r0.rsp_valid}, 0);
      chk("rst_rsp1_v", {63'd0, r1.rsp_valid}, 0);
      chk("rst_p", r0.p | r1.p, 0);
      chk("rst_mul", {mul_a, mul_b}, 0);
      r0.valid = 0;
      @(posedge clk); #1 rst = 0;
      send(0, 7, 32'hFFFFFFFD);
      drop(0);
      wait_rsp(0, 64'hFFFFFFFFFFFFFFEB, "single");
      chk("single_rsp1", {63'd0, r1.rsp_valid}, 0);
      drain();
      do_reset();
      gq.delete();
      fork
         begin send(0, 2, 3); drop(0); end
         begin send(1, 5, 5); drop(1); end
         begin wait_rsp(0, 6, "sim_p0"); wait_rsp(1, 25, "sim_p1"); end
      join
      drain();
      chk("sim_n", 64'(gq.size()), 2);
      for (int i = 0; i < gq.size(); i++) chk("sim_order", 64'(gq[i]), 64'(i % 2));
      chk("sim_gap", 64'(acc_cyc[1] - pop_cyc[0]), 1);
      do_reset();
      gq.delete();
      fork
         begin for (int i = 0; i < 3; i++) send(0, 32'(i + 1), 100); drop(0); end
         begin for (int j = 0; j < 3; j++) send(1, 32'(j + 10), 32'hFFFFFFF9); drop(1); end
      join
      drain();
      chk("fair_n", 64'(gq.size()), 6);
      for (int i = 0; i < gq.size(); i++) chk("fair_g", 64'(gq[i]), 64'(i % 2));
      gq.delete();
      send(0, 3, 4);
      send(0, 32'hFFFFFFFB, 6);
      drop(0);
      drain();
      chk("lone_n", 64'(gq.size()), 2);
      for (int i = 0; i < gq.size(); i++) chk("lone_g", 64'(gq[i]), 0);
      r1.rsp_ready = 0;
      send(1, 32'h12345, 32'hFFFF0001);
      drop(1);
      wait_rsp(1, prod(32'h12345, 32'hFFFF0001), "bp_p");
      hold_p = r1.p;
      @(posedge clk); #1 r0.a = 9; r0.b = 9; r0.valid = 1;
      repeat (50) begin
         @(negedge clk);
         chk("bp_valid", {63'd0, r1.rsp_valid}, 1);
         chk("bp_stable", r1.p, hold_p);
         chk("bp_ready", {62'd0, r0.ready, r1.ready}, 0);
         chk("bp_busy", {63'd0, busy}, 1);
      end
      @(posedge clk); #1 r1.rsp_ready = 1;
      @(negedge clk);
      chk("bp_no_accept", {63'd0, r0.ready}, 0);
      @(negedge clk);
      chk("bp_done", {63'd0, r1.rsp_valid}, 0);
      chk("bp_idle", {63'd0, busy}, 0);
      chk("bp_next", {63'd0, r0.ready}, 1);
      @(posedge clk); #1 r0.valid = 0;
      drain();
      send(0, 11, 13);
      drop(0);
      repeat (10) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("abort_busy", {63'd0, busy}, 0);
      chk("abort_rsp", {62'd0, r0.rsp_valid, r1.rsp_valid}, 0);
      seen = 0;
      repeat (60) begin @(negedge clk); if (r0.rsp_valid || r1.rsp_valid) seen++; end
      chk("abort_stale", 64'(seen), 0);
      send(0, 32'h80000000, 32'h80000000);
      drop(0);
      wait_rsp(0, 64'h4000000000000000, "ext1");
      drain();
      send(1, 32'h7FFFFFFF, 32'hFFFFFFFF);
      drop(1);
      wait_rsp(1, 64'hFFFFFFFF80000001, "ext2");
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 36, meaning: cycles operands are held on the shared multiplier before its product is captured; must be at least 2 x 18, the multiplier's free-running period.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has operands.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands, two's complement.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006, for requester 1.
REQ-008 rsp0_valid  output  1  product available for requester 0.
REQ-009 rsp0_ready  input  1  requester 0 takes product.
REQ-010 rsp0_p  output  64  signed product for requester 0.
REQ-011 rsp1_valid, rsp1_ready, rsp1_p  same as REQ-008..010, for requester 1.
REQ-012 mul_a, mul_b  output  32 each  registered operands driven to the shared 32x32->64 multiplier.
REQ-013 mul_out  input  64  product from the shared multiplier.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and RESP.
REQ-016 The block SHALL keep a 1-bit round-robin pointer naming the preferred requester.
REQ-017 In IDLE, grant SHALL go to the preferred requester if its valid is high, otherwise to the other requester if its valid is high, otherwise to nobody.
REQ-018 reqN_ready SHALL be combinational and high only in IDLE for the granted requester; at most one ready SHALL be high in any cycle.
REQ-019 Handshake SHALL complete when valid and ready are both high: mul_a and mul_b load the granted operands, the owner is recorded, the hold counter clears to 0 and the FSM enters RUN on the next edge.
REQ-020 In RUN, mul_a and mul_b SHALL stay stable and the counter SHALL increment every cycle.
REQ-021 In the cycle where counter equals HOLD_CYCLES-1, the block SHALL register mul_out into the result register and enter RESP.
- Accept-to-rsp_valid latency is exactly HOLD_CYCLES+1 edges.
REQ-022 In RESP, rspN_valid SHALL be high for the owner only, and rspN_p SHALL show the result register.
REQ-023 The response SHALL hold until rspN_ready is high; that edge returns the FSM to IDLE and sets the pointer to the non-owner.
- rsp_ready low stalls the block indefinitely with the result stable.
REQ-024 rspN_ready asserted while rspN_valid is low SHALL have no effect.
REQ-025 A new request SHALL NOT be accepted in the same cycle a response completes; the earliest accept is the following IDLE cycle.
REQ-026 Request valids seen in RUN or RESP SHALL be ignored; a requester must hold valid until it sees ready.
REQ-027 The product SHALL be exactly the multiplier's result, the full 64-bit signed product of a and b; the arbiter SHALL NOT modify it.
REQ-028 The counter SHALL be wide enough for HOLD_CYCLES-1 and SHALL NOT wrap during RUN.
REQ-029 A lone active requester SHALL be granted back-to-back even though the pointer flips toward the idle requester.

Reset
REQ-030 When rst is high at a clock edge, the next state SHALL be: FSM in IDLE, pointer 0, counter 0, owner 0, result register 0, mul_a and mul_b 0.
- Consequently busy, rsp0_valid and rsp1_valid are 0, and rsp0_p and rsp1_p are 0.
REQ-031 Reset asserted in RUN or RESP SHALL abort the operation and discard its product; no response is issued for it.
REQ-032 reqN_ready SHALL be 0 in any cycle where rst is high.

Verification
REQ-033 Single request: req0 with a=7, b=-3 accepted in cycle T -> rsp0_valid rises at edge T+37, rsp0_p=0xFFFFFFFFFFFFFFEB, rsp1_valid stays 0.
REQ-034 Simultaneous requests after reset: req0 (a=2, b=3) and req1 (a=5, b=5).
- req0 is granted first and returns 6.
- req1 is then granted in the IDLE cycle after rsp0 handshakes and returns 25.
REQ-035 Fairness: both requesters held valid for 6 transactions -> grants alternate 0,1,0,1,0,1 with no two consecutive grants to one requester.
REQ-036 Back-pressure: rsp1_ready held low for 50 cycles -> rsp1_valid and rsp1_p stay stable, both readies stay 0, busy=1; the response completes the cycle rsp1_ready rises.
REQ-037 Reset mid-RUN: rst pulsed for 1 cycle at counter=10 -> next cycle is IDLE with busy=0 and both rsp_valid=0; no stale product appears later.
REQ-038 Extremes, each run alone:
- a=0x80000000, b=0x80000000 -> 0x4000000000000000.
- a=0x7FFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF80000001.
